keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans the 4x4 Pmod keypad by driving one column low at a time and sampling the pulled-up row lines. Each full scan yields at most one key. A press is accepted only after several identical consecutive scans. The block outputs a held 4-bit hex key code, a level "key held" flag and single-cycle press/release strobes. It sits directly upstream of the two-digit seven-segment display logic and replaces its raw decoder plus external debounce.

## Interface
- `SETTLE_CYC`, 50_000 — cycles each column is driven before its rows are sampled (1 ms at 50 MHz); minimum 4.
- `DEBOUNCE_SCANS`, 4 — consecutive identical full-scan results required to accept a state change; minimum 1.
- `clk`  in  1 — system clock, 50 MHz from the clock wizard.
- `rst_n`  in  1 — asynchronous, active-low reset. Deassertion is synchronised externally.
- `col`  out  4 — column drive, active-low, exactly one bit low at all times.
- `row`  in  4 — row sense, active-low, asynchronous to `clk`, pulled up externally.
- `key_code`  out  4 — last accepted key, hex value.
- `key_valid`  out  1 — high while an accepted key is held.
- `key_press`  out  1 — one-cycle strobe when a new key is accepted.
- `key_release`  out  1 — one-cycle strobe when the held key is released.

## Operation
- `row` passes through a 2-flop synchroniser, reset value 4'hF.
- Column FSM states are `COL0`..`COL3`, with the drive pattern `col = ~(4'b0001 << idx)`.
  - Each state lasts `SETTLE_CYC` cycles, counted by the settle counter.
  - On the last cycle of the state, the synchronised row is sampled.
  - The FSM then moves `COL0`→`COL1`→`COL2`→`COL3`→`COL0`.
- Key map, indexed [row][col]:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: 0 F E D
- Scan priority: the first low row bit found wins. Columns are checked in ascending order, and rows in ascending order within a column. Later hits in the same scan are ignored, so multi-key presses report only the highest-priority key.
- Scan result is the pair {hit, code}. When there is no hit, code is 0.
- End of scan is the cycle the `COL3` sample is taken. At that point:
  - If the result equals the candidate, `stable_cnt` increments, saturating at `DEBOUNCE_SCANS`.
  - Otherwise the result is loaded as the new candidate and `stable_cnt` is set to 1.
- When `stable_cnt` equals `DEBOUNCE_SCANS` and the candidate differs from the accepted state, the candidate becomes the accepted state. The transitions are:
  - none → k: `key_press`, `key_code` = k, `key_valid` = 1.
  - k1 → k2 with no gap: `key_press` only, `key_code` = k2, `key_valid` stays 1.
  - k → none: `key_release`, `key_valid` = 0, `key_code` keeps k.
- `key_press` and `key_release` are never high in the same cycle.
- Reset values:
  - `col` = 4'b1110, in state `COL0`
  - settle counter 0
  - candidate none, `stable_cnt` 0
  - `key_code` 0, `key_valid` 0, `key_press` 0, `key_release` 0
- Reset asserted mid-scan or mid-debounce aborts immediately. No strobe is emitted on reset.

## Timing
- Column period is `SETTLE_CYC` cycles. A full scan is 4×`SETTLE_CYC` cycles.
- Row sample is taken on cycle `SETTLE_CYC`-1 of the column. The 2-cycle synchroniser latency must fit inside the settle window.
- Outputs are registered. Strobes and `key_code`/`key_valid` updates appear in the cycle after the accepting end-of-scan cycle.
- Press latency, measured from the row being stable before the start of a scan: `DEBOUNCE_SCANS` full scans + 1 cycle.
- Worst case, when the press lands just after its column was sampled: (`DEBOUNCE_SCANS`+1) scans + 1 cycle.
- Release latency is the same.
- A bounce lasting less than one scan period never reaches `DEBOUNCE_SCANS` and produces no strobe.

## Structure
- Package `kypd_pkg` holds:
  - the `col_state_t` enum (`COL0`..`COL3`)
  - the `KEY_MAP` 4x4 array of 4-bit constants
  - the `scan_result_t` struct {hit, code}
- Sub-module `kypd_row_sync`: a parameterised-width 2-flop synchroniser with asynchronous active-low reset to all-ones.
- Counter widths:
  - settle counter: `$clog2(SETTLE_CYC)`
  - `stable_cnt`: `$clog2(DEBOUNCE_SCANS+1)`

## Test plan
Bench overrides `SETTLE_CYC`=4 and `DEBOUNCE_SCANS`=2. Its keypad model pulls row r low whenever the pressed key's column is driven low.
- Reset, then idle for 3 scans → `col` cycles 1110, 1101, 1011, 0111 with each pattern held 4 cycles; `key_press`, `key_release` and `key_valid` stay 0.
- Hold key '6' (row 1, col 2) → exactly one `key_press` after at most 3 scans + 1 cycle; `key_code`=4'h6 and `key_valid`=1 while held; release → one `key_release`, and `key_code` stays 6.
- Toggle key '5' every 3 cycles for 5 scans, then hold it → no strobe during the toggling; a single `key_press` with code 5 once it is stable.
- Hold '1' and 'D' together → `key_code`=1; release '1' only → `key_press` with code D and no `key_release` in between.
- Press 'A', then assert `rst_n` low mid-`COL2` for 3 cycles → outputs return to reset values; after release 'A' is re-accepted with one fresh `key_press`.
- Move directly from '0' to 'F' with no idle gap → `key_press` for F, `key_valid` never drops.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the column FSM encoding, the key map and the per-scan result type.
package kypd_pkg;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } scan_result_t;

    // Indexed [row][col].
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    // Lowest-numbered low row in the driven column wins; no hit reports code 0.
    function automatic scan_result_t scan_column(input logic [3:0] row_n,
                                                 input logic [1:0] col_idx);
        scan_result_t res;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            if (!res.hit && !row_n[r]) begin
                res.hit  = 1'b1;
                res.code = KEY_MAP[r][col_idx];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/kypd_row_sync.sv
// Two-flop synchroniser for the pulled-up, active-low row lines.
// Resets to all-ones so an idle keypad is seen during and after reset.
module kypd_row_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column sweep, priority key pick per scan, scan-level debounce,
// and registered key code / held flag / press and release strobes.
module keypad_scanner
    import kypd_pkg::*;
#(
    parameter int unsigned SETTLE_CYC     = 50_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press,
    output logic       key_release
);

    localparam int unsigned SW = $clog2(SETTLE_CYC);
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] STABLE_MAX  = CW'(DEBOUNCE_SCANS);

    col_state_t   r_state;
    col_state_t   w_state_next;
    logic [SW-1:0] r_settle;
    logic [3:0]   w_row_sync;
    logic         w_sample;
    logic         w_end_of_scan;
    scan_result_t w_col_hit;
    scan_result_t w_scan;
    scan_result_t r_partial;
    scan_result_t r_cand;
    scan_result_t w_cand_next;
    logic [CW-1:0] r_stable_cnt;
    logic [CW-1:0] w_stable_next;
    logic         w_differs;
    logic         w_accept;
    logic [3:0]   r_key_code;
    logic         r_key_valid;
    logic         r_key_press;
    logic         r_key_release;

    kypd_row_sync #(
        .WIDTH (4)
    ) u_row_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (row),
        .o_sync  (w_row_sync)
    );

    assign w_sample      = (r_settle == SETTLE_LAST);
    assign w_end_of_scan = w_sample && (r_state == COL3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle <= '0;
        end else if (w_sample) begin
            r_settle <= '0;
        end else begin
            r_settle <= r_settle + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COL0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_sample) begin
            unique case (r_state)
                COL0: w_state_next = COL1;
                COL1: w_state_next = COL2;
                COL2: w_state_next = COL3;
                COL3: w_state_next = COL0;
            endcase
        end
    end

    always_comb begin
        col = ~(4'b0001 << r_state);
    end

    // COL0 starts a fresh scan; later columns only fill in if nothing was found yet.
    always_comb begin
        w_col_hit = scan_column(w_row_sync, r_state);
        if ((r_state == COL0) || !r_partial.hit) begin
            w_scan = w_col_hit;
        end else begin
            w_scan = r_partial;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_partial <= '0;
        end else if (w_sample) begin
            r_partial <= w_scan;
        end
    end

    always_comb begin
        w_cand_next   = r_cand;
        w_stable_next = r_stable_cnt;
        if (w_end_of_scan) begin
            if (w_scan == r_cand) begin
                if (r_stable_cnt != STABLE_MAX) begin
                    w_stable_next = r_stable_cnt + 1'b1;
                end
            end else begin
                w_cand_next   = w_scan;
                w_stable_next = CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand       <= '0;
            r_stable_cnt <= '0;
        end else begin
            r_cand       <= w_cand_next;
            r_stable_cnt <= w_stable_next;
        end
    end

    // The accepted state is {key_valid, key_code}; key_code is stale while no key is held.
    always_comb begin
        w_differs = (w_cand_next.hit != r_key_valid) ||
                    (w_cand_next.hit && (w_cand_next.code != r_key_code));
        w_accept  = w_end_of_scan && (w_stable_next == STABLE_MAX) && w_differs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_key_press   <= w_accept && w_cand_next.hit;
            r_key_release <= w_accept && !w_cand_next.hit;
            if (w_accept) begin
                r_key_valid <= w_cand_next.hit;
                if (w_cand_next.hit) begin
                    r_key_code <= w_cand_next.code;
                end
            end
        end
    end

    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_press   = r_key_press;
    assign key_release = r_key_release;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives the rows, a scan-level
// reference model predicts strobes, and a negedge monitor pops and compares them.
module tb_keypad_scanner;

    localparam int SETTLE = 4;
    localparam int DB     = 2;
    localparam int SCAN   = 4 * SETTLE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_press;
    logic        key_release;
    logic [15:0] pressed = '0;

    int total = 0;
    int bad = 0;
    int n_press = 0;
    int n_release = 0;
    int cyc = 0;
    bit watch_valid = 1'b0;
    int valid_drops = 0;

    typedef struct {
        bit         press;
        logic [3:0] code;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    logic       exp_valid = 1'b0;
    logic [3:0] exp_code = 4'h0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SETTLE_CYC     (SETTLE),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col         (col),
        .row         (row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_press   (key_press),
        .key_release (key_release)
    );

    // Key at position r*4+c pulls row r low whenever column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [3:0] key_at(input int idx);
        logic [63:0] map;
        map = 64'h123A_456B_789C_0FED;
        return map[60-4*idx +: 4];
    endfunction

    function automatic logic [3:0] exp_col(input int n);
        logic [3:0] one;
        one = 4'b0001 << ((n / SETTLE) % 4);
        return ~one;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: rows reach the sampler two cycles late; a scan's key is the first
    // pressed key in (column, row) order; a change is accepted once DB scans agree.
    initial begin
        logic [15:0] m1, m2;
        logic [15:0] snap [4];
        logic [4:0]  hist[$];
        logic [4:0]  res;
        logic [4:0]  acc;
        int          k, c;
        bit          same;
        m1 = '0;
        m2 = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m1 = '0;
                m2 = '0;
                hist.delete();
                exp_q.delete();
                exp_valid = 1'b0;
                exp_code  = 4'h0;
            end else begin
                k = cyc;
                if (k % SETTLE == SETTLE - 1) begin
                    c = (k / SETTLE) % 4;
                    snap[c] = m2;
                    if (c == 3) begin
                        res = '0;
                        for (int cc = 0; cc < 4; cc++) begin
                            for (int r = 0; r < 4; r++) begin
                                if (!res[4] && snap[cc][r*4+cc]) res = {1'b1, key_at(r*4+cc)};
                            end
                        end
                        hist.push_back(res);
                        if (hist.size() > DB) void'(hist.pop_front());
                        same = (hist.size() == DB);
                        foreach (hist[i]) if (hist[i] != res) same = 1'b0;
                        acc = exp_valid ? {1'b1, exp_code} : 5'h00;
                        if (same && res != acc) begin
                            if (res[4]) begin
                                exp_q.push_back('{1'b1, res[3:0], k + 1});
                                exp_code  = res[3:0];
                                exp_valid = 1'b1;
                            end else begin
                                exp_q.push_back('{1'b0, exp_code, k + 1});
                                exp_valid = 1'b0;
                            end
                        end
                    end
                end
                m2 = m1;
                m1 = pressed;
            end
        end
    end

    // Monitor: every strobe must match the head of the queue, on the predicted cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_press)   n_press++;
            if (key_release) n_release++;
            if (watch_valid && !key_valid) valid_drops++;
            check("strobe_exclusive", {31'd0, key_press & key_release}, 32'd0);
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                check("strobe_missing_at", cyc, exp_q[0].at);
                void'(exp_q.pop_front());
            end
            if (key_press || key_release) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, key_press, key_release}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", {31'd0, key_press}, {31'd0, e.press});
                    check("strobe_code", {28'd0, key_code}, {28'd0, e.code});
                    check("strobe_cycle", cyc, e.at);
                end
            end
            check("key_valid", {31'd0, key_valid}, {31'd0, exp_valid});
            check("key_code", {28'd0, key_code}, {28'd0, exp_code});
            check("col", {28'd0, col}, {28'd0, exp_col(cyc)});
        end
    end

    task automatic hold(input logic [15:0] m, input int n);
        pressed = m;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_press(input int base, input string name);
        int t;
        t = 0;
        while (n_press == base && t <= 3 * SCAN + 2) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, {31'd0, t <= 3 * SCAN + 2}, 32'd1);
    endtask

    initial begin
        int p, r, t;
        logic [15:0] m;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        hold('0, 3 * SCAN);
        check("idle_press", n_press, 0);
        check("idle_release", n_release, 0);

        // Key '6': row 1, col 2
        p = n_press;
        pressed = 16'h0040;
        wait_press(p, "latency_6");
        hold(16'h0040, 2 * SCAN);
        check("press_count_6", n_press - p, 1);
        check("code_6", {28'd0, key_code}, 32'h6);
        check("valid_6", {31'd0, key_valid}, 32'd1);
        r = n_release;
        hold('0, 4 * SCAN);
        check("release_count_6", n_release - r, 1);
        check("code_kept_6", {28'd0, key_code}, 32'h6);
        check("valid_off_6", {31'd0, key_valid}, 32'd0);

        // Key '5' bouncing every 3 cycles, then held
        for (int i = 0; i < 27; i++) hold((i % 2 == 0) ? 16'h0020 : 16'h0000, 3);
        hold(16'h0020, 4 * SCAN);
        check("code_5", {28'd0, key_code}, 32'h5);
        check("valid_5", {31'd0, key_valid}, 32'd1);
        hold('0, 4 * SCAN);

        // '1' and 'D' together, then release '1'
        hold(16'h8001, 4 * SCAN);
        check("code_1_over_D", {28'd0, key_code}, 32'h1);
        p = n_press;
        r = n_release;
        hold(16'h8000, 4 * SCAN);
        check("code_D", {28'd0, key_code}, 32'hD);
        check("press_count_D", n_press - p, 1);
        check("no_release_1_to_D", n_release - r, 0);
        hold('0, 4 * SCAN);

        // 'A' then reset mid-COL2
        hold(16'h0008, 4 * SCAN);
        check("code_A", {28'd0, key_code}, 32'hA);
        t = 0;
        while (col != 4'b1011 && t < 2 * SCAN) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_code", {28'd0, key_code}, 32'h0);
        check("rst_col", {28'd0, col}, 32'hE);
        check("rst_strobes", {30'd0, key_press, key_release}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        p = n_press;
        wait_press(p, "latency_A_after_reset");
        check("code_A_again", {28'd0, key_code}, 32'hA);
        hold(16'h0008, SCAN);
        hold('0, 4 * SCAN);

        // '0' straight to 'F'
        hold(16'h1000, 4 * SCAN);
        check("code_0", {28'd0, key_code}, 32'h0);
        check("valid_0", {31'd0, key_valid}, 32'd1);
        watch_valid = 1'b1;
        hold(16'h2000, 4 * SCAN);
        watch_valid = 1'b0;
        check("code_F", {28'd0, key_code}, 32'hF);
        check("valid_never_dropped", valid_drops, 0);
        hold('0, 4 * SCAN);

        // Random holds of zero, one or two keys
        for (int i = 0; i < 30; i++) begin
            m = '0;
            case ($urandom % 4)
                0: m = '0;
                1, 2: m[$urandom % 16] = 1'b1;
                default: begin
                    m[$urandom % 16] = 1'b1;
                    m[$urandom % 16] = 1'b1;
                end
            endcase
            hold(m, $urandom_range(1, 3 * SCAN));
        end
        hold('0, 4 * SCAN);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
